// File: rtl/serializer_using_mux.sv
// serializer_using_mux: valid/ready parallel-to-serial stage whose serial bit is picked by a 2:1 mux tree.
module serializer_mux2 (
    input  logic sel,
    input  logic d0,
    input  logic d1,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

module serializer_using_mux #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int INVERT    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             down_valid,
    input  logic             down_ready,
    output logic             down_data,
    output logic             down_last
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam int L = $clog2(WIDTH);
    localparam int N = 1 << L;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] word, word_n;
    logic [CW-1:0] cnt, cnt_n, idx;
    logic bit_o, at_last, beat, load;
    assign idx = (MSB_FIRST != 0) ? LAST - cnt : cnt;
    if (L == 0) begin : g_pass
        assign bit_o = word[0];
    end else begin : g_tree
        logic [N-1:0] leaves;
        assign leaves = N'(word);
        // Level d halves the candidates using select bit d; padded leaves are never selected.
        for (genvar d = 0; d < L; d++) begin : lv
            logic [(N>>d)-1:0] v;
            logic [(N>>(d+1))-1:0] o;
            if (d == 0) begin : g_leaf
                assign v = leaves;
            end else begin : g_up
                assign v = lv[d-1].o;
            end
            for (genvar p = 0; p < (N >> (d + 1)); p++) begin : mx
                serializer_mux2 u_mux (.sel(idx[d]), .d0(v[2*p]), .d1(v[2*p+1]), .y(o[p]));
            end
        end
        assign bit_o = lv[L-1].o[0];
    end
    always_comb begin
        at_last    = cnt == LAST;
        down_valid = !rst && state == SHIFT;
        up_ready   = !rst && (state == IDLE || (down_ready && at_last));
        beat       = down_valid && down_ready;
        load       = up_valid && up_ready;
        down_last  = down_valid && at_last;
        down_data  = down_valid && (bit_o ^ (INVERT != 0));
        state_n    = state;
        word_n     = word;
        cnt_n      = cnt;
        if (load) begin
            state_n = SHIFT;
            word_n  = up_data;
            cnt_n   = '0;
        end else if (beat) begin
            state_n = at_last ? IDLE : SHIFT;
            cnt_n   = at_last ? cnt : cnt + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            word  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            word  <= word_n;
            cnt   <= cnt_n;
        end
    end
endmodule

// File: tb/tb_serializer_using_mux.sv
// tb_serializer_using_mux: scoreboard bench over four parameter variants of the serializer.
module tb_serializer_using_mux;
    logic clk = 0, rst = 1;
    logic uv [4], ur [4], dv [4], dr [4], dd [4], dl [4];
    logic [7:0] ud [4];
    logic [1:0] q [4][$];
    int beats [4];
    int checks = 0, failures = 0, wt;
    localparam int W [4] = '{8, 8, 8, 1};
    always #5 clk = ~clk;

    serializer_using_mux #(.WIDTH(8), .MSB_FIRST(1), .INVERT(0)) u_msb (.clk(clk), .rst(rst),
        .up_valid(uv[0]), .up_ready(ur[0]), .up_data(ud[0]), .down_valid(dv[0]),
        .down_ready(dr[0]), .down_data(dd[0]), .down_last(dl[0]));
    serializer_using_mux #(.WIDTH(8), .MSB_FIRST(0), .INVERT(0)) u_lsb (.clk(clk), .rst(rst),
        .up_valid(uv[1]), .up_ready(ur[1]), .up_data(ud[1]), .down_valid(dv[1]),
        .down_ready(dr[1]), .down_data(dd[1]), .down_last(dl[1]));
    serializer_using_mux #(.WIDTH(8), .MSB_FIRST(1), .INVERT(1)) u_inv (.clk(clk), .rst(rst),
        .up_valid(uv[2]), .up_ready(ur[2]), .up_data(ud[2]), .down_valid(dv[2]),
        .down_ready(dr[2]), .down_data(dd[2]), .down_last(dl[2]));
    serializer_using_mux #(.WIDTH(1), .MSB_FIRST(1), .INVERT(0)) u_w1 (.clk(clk), .rst(rst),
        .up_valid(uv[3]), .up_ready(ur[3]), .up_data(ud[3][0:0]), .down_valid(dv[3]),
        .down_ready(dr[3]), .down_data(dd[3]), .down_last(dl[3]));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // e holds the expected serial bits in output order, first bit in e[n-1].
    task automatic put(input int k, input logic [7:0] w, input logic [7:0] e, input int n, output int waited);
        logic ok = 0;
        for (int i = 0; i < n; i++) q[k].push_back({e[n-1-i], 1'(i == W[k] - 1)});
        uv[k] = 1;
        ud[k] = w;
        waited = 0;
        while (!ok && waited < 50) begin
            @(negedge clk);
            waited++;
            ok = ur[k];
        end
        chk("up_handshake", int'(ok), 1);
        step;
    endtask

    task automatic drain;
        int t = 0;
        while (t < 100 && (q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0) begin
            step;
            t++;
        end
        chk("drain", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (dv[k]) begin
                    chk("up_ready_in_shift", int'(ur[k]), int'(dr[k] && dl[k]));
                    if (dr[k]) begin
                        beats[k]++;
                        if (q[k].size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_beat dut=%0d actual=%0b expected=none", k, dd[k]);
                        end else begin
                            logic [1:0] e;
                            e = q[k].pop_front();
                            chk("beat_data", int'(dd[k]), int'(e[1]));
                            chk("beat_last", int'(dl[k]), int'(e[0]));
                        end
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            uv[k] = 0;
            ud[k] = 0;
            dr[k] = 1;
            beats[k] = 0;
        end
        repeat (2) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                chk("rst_up_ready", int'(ur[k]), 0);
                chk("rst_down_valid", int'(dv[k]), 0);
                chk("rst_down_data", int'(dd[k]), 0);
                chk("rst_down_last", int'(dl[k]), 0);
            end
            step;
        end
        rst = 0;
        @(negedge clk);
        chk("release_up_ready", int'(ur[0]), 1);
        chk("release_down_valid", int'(dv[0]), 0);
        step;
        put(0, 8'hA5, 8'hA5, 8, wt);
        uv[0] = 0;
        repeat (8) step;
        @(negedge clk);
        chk("idle_after_word", int'(dv[0]), 0);
        step;
        put(0, 8'hA5, 8'hA5, 8, wt);
        uv[0] = 0;
        step;
        step;
        dr[0] = 0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_valid", int'(dv[0]), 1);
            chk("bp_data", int'(dd[0]), 1);
            chk("bp_last", int'(dl[0]), 0);
            step;
        end
        dr[0] = 1;
        drain;
        begin
            int b;
            put(0, 8'hFF, 8'hFF, 8, wt);
            b = beats[0];
            put(0, 8'h00, 8'h00, 8, wt);
            uv[0] = 0;
            chk("b2b_ready_wait", wt, 8);
            chk("b2b_first_beats", beats[0] - b, 8);
        end
        repeat (8) begin
            @(negedge clk);
            chk("b2b_contiguous", int'(dv[0]), 1);
        end
        @(negedge clk);
        chk("b2b_idle", int'(dv[0]), 0);
        step;
        put(1, 8'h01, 8'b1000_0000, 8, wt);
        uv[1] = 0;
        put(2, 8'hA5, 8'h5A, 8, wt);
        uv[2] = 0;
        put(3, 8'h01, 8'h01, 1, wt);
        uv[3] = 0;
        drain;
        put(0, 8'hA5, 8'b101, 3, wt);
        uv[0] = 0;
        step;
        step;
        step;
        rst = 1;
        @(negedge clk);
        chk("midrst_valid", int'(dv[0]), 0);
        chk("midrst_ready", int'(ur[0]), 0);
        step;
        rst = 0;
        @(negedge clk);
        chk("postrst_valid", int'(dv[0]), 0);
        chk("postrst_ready", int'(ur[0]), 1);
        step;
        put(0, 8'h3C, 8'h3C, 8, wt);
        uv[0] = 0;
        drain;
        repeat (2) step;
        chk("beats_msb", beats[0], 43);
        chk("beats_lsb", beats[1], 8);
        chk("beats_inv", beats[2], 8);
        chk("beats_w1", beats[3], 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
